// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: PS/2 pin inputs, consumer handshake and FIFO status of the receiver
interface ps2_rx_fifo_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic          clk_ps2;
   logic          data_ps2;
   logic          read_enable;
   logic          byte_pop;
   logic [7:0]    byte_data;
   logic [1:0]    byte_error_code;
   logic          byte_valid;
   logic [CW-1:0] fifo_count;
   logic          frame_timeout;
   logic          overflow;
   modport master (
      output clk_ps2, data_ps2, read_enable, byte_pop,
      input  byte_data, byte_error_code, byte_valid, fifo_count, frame_timeout, overflow
   );
   modport slave (
      input  clk_ps2, data_ps2, read_enable, byte_pop,
      output byte_data, byte_error_code, byte_valid, fifo_count, frame_timeout, overflow
   );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with clock glitch filter, frame timeout, parity modes and FWFT byte FIFO
module ps2_rx_fifo #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int TIMEOUT_US  = 1000,
   parameter int FILTER_LEN  = 8,
   parameter int PARITY_MODE = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input logic          CLK,
   input logic          RESET,
   ps2_rx_fifo_if.slave bus
);
   localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, PUSH} state_t;
   state_t        state, state_nx;
   logic          c_meta, c_sync, d_meta, d_sync;
   logic          c_filt, c_filt_d;
   logic [7:0]    filt_cnt;
   logic          fe, busy, tmo;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          perr, serr;
   logic [TW-1:0] timer;
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] count;
   logic          empty, full, push, pop, wr, ovf;

   // two-flop synchronisers; both lines idle high
   always_ff @(posedge CLK)
      if (RESET) {c_meta, c_sync, d_meta, d_sync} <= '1;
      else {c_meta, c_sync, d_meta, d_sync} <= {bus.clk_ps2, c_meta, bus.data_ps2, d_meta};

   // filtered clock follows the synchronised clock only after FILTER_LEN consecutive differing samples
   always_ff @(posedge CLK)
      if (RESET) begin
         c_filt   <= 1'b1;
         c_filt_d <= 1'b1;
         filt_cnt <= '0;
      end else begin
         c_filt_d <= c_filt;
         if (c_sync == c_filt) filt_cnt <= '0;
         else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
            c_filt   <= c_sync;
            filt_cnt <= '0;
         end else filt_cnt <= filt_cnt + 1'b1;
      end

   assign fe   = c_filt_d & ~c_filt;
   assign busy = state inside {DATA, PARITY, STOP};
   assign tmo  = busy && !fe && timer == TW'(TIMEOUT_CYCLES - 1);

   // frame state register
   always_ff @(posedge CLK)
      if (RESET) state <= IDLE;
      else state <= state_nx;

   // frame sequencing; an expired inter-edge gap abandons the frame
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (fe && bus.read_enable && !d_sync) ? DATA : IDLE;
         DATA:    state_nx = (fe && bit_cnt == 3'd7) ? ((PARITY_MODE == 2) ? STOP : PARITY) : DATA;
         PARITY:  state_nx = fe ? STOP : PARITY;
         STOP:    state_nx = fe ? PUSH : STOP;
         PUSH:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (tmo) state_nx = IDLE;
   end

   // bit shifting, parity/stop checks and the inter-edge timer
   always_ff @(posedge CLK)
      if (RESET) begin
         timer   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         perr    <= 1'b0;
         serr    <= 1'b0;
      end else begin
         timer <= (busy && !fe && !tmo) ? timer + 1'b1 : '0;
         if (state == IDLE) begin
            bit_cnt <= '0;
            if (state_nx == DATA) {perr, serr} <= 2'b00;
         end
         if (state == DATA && fe) begin
            shreg   <= {d_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (state == PARITY && fe) perr <= (^{shreg, d_sync}) ^ (PARITY_MODE == 0);
         if (state == STOP && fe) serr <= ~d_sync;
      end

   assign empty = count == '0;
   assign full  = count == CW'(FIFO_DEPTH);
   assign push  = state == PUSH;
   assign pop   = bus.byte_pop && !empty;
   assign wr    = push && (!full || pop);

   // FIFO storage, written only when there is room or the head leaves in the same cycle
   always_ff @(posedge CLK)
      if (wr) mem[wp] <= {serr, perr, shreg};

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge CLK)
      if (RESET) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         wp    <= wr ? wp + 1'b1 : wp;
         rp    <= pop ? rp + 1'b1 : rp;
         count <= count + CW'(wr) - CW'(pop);
         ovf   <= ovf | (push && full && !pop);
      end

   assign {bus.byte_error_code, bus.byte_data} = empty ? 10'd0 : mem[rp];
   assign bus.byte_valid    = !empty;
   assign bus.fifo_count    = count;
   assign bus.frame_timeout = tmo;
   assign bus.overflow      = ovf;
endmodule
